// File: rtl/button_event_scheduler.sv
// button_event_scheduler: per-button press/auto-repeat event generation shared through a round-robin output slot
module button_event_scheduler #(
  parameter int N_BTN         = 5,
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int ID_W          = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_repeat,
  output logic [N_BTN-1:0] overflow,
  input  logic             ovf_clr
);
  localparam int MAXD = HOLD_DELAY > REPEAT_PERIOD ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXD);
  typedef enum logic [1:0] {IDLE, HOLD, REPT} state_t;
  logic [N_BTN-1:0] btn_q, btn_d, pending_q, pending_d, pend_rep_q, pend_rep_d;
  logic [N_BTN-1:0] overflow_q, overflow_d, emit, emit_rep, consume;
  logic             post_rst_q, post_rst_d, valid_q, valid_d, rep_q, rep_d;
  logic [ID_W-1:0]  id_q, id_d, rr_q, rr_d, win, win_hi, win_lo;
  logic             any_hi, any_lo, rep_hi, rep_lo, win_rep, load;
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t          st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            emit_b, emit_rep_b;
    assign emit[i]     = emit_b;
    assign emit_rep[i] = emit_rep_b;
    // press detection and hold/repeat timing; a button still held across reset is ignored until re-pressed
    always_comb begin
      st_d       = st_q;
      cnt_d      = cnt_q;
      emit_b     = 1'b0;
      emit_rep_b = 1'b0;
      case (st_q)
        IDLE: if (btn_in[i] && !btn_q[i] && !post_rst_q) begin
          emit_b = 1'b1;
          cnt_d  = '0;
          st_d   = HOLD;
        end
        HOLD: if (!btn_in[i]) st_d = IDLE;
          else if (cnt_q == CW'(HOLD_DELAY - 1)) begin
            emit_b     = 1'b1;
            emit_rep_b = 1'b1;
            cnt_d      = '0;
            st_d       = REPT;
          end else cnt_d = cnt_q + 1'b1;
        REPT: if (!btn_in[i]) st_d = IDLE;
          else if (cnt_q == CW'(REPEAT_PERIOD - 1)) begin
            emit_b     = 1'b1;
            emit_rep_b = 1'b1;
            cnt_d      = '0;
          end else cnt_d = cnt_q + 1'b1;
        default: st_d = IDLE;
      endcase
    end
    // per-button state and counter registers
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end
  end
  // round-robin pick: lowest pending index at or above rr_ptr, else lowest pending overall
  always_comb begin
    any_hi  = 1'b0;
    any_lo  = 1'b0;
    win_hi  = '0;
    win_lo  = '0;
    rep_hi  = 1'b0;
    rep_lo  = 1'b0;
    consume = '0;
    for (int j = N_BTN - 1; j >= 0; j--) begin
      if (pending_q[j]) begin
        any_lo = 1'b1;
        win_lo = ID_W'(j);
        rep_lo = pend_rep_q[j];
      end
      if (pending_q[j] && ID_W'(j) >= rr_q) begin
        any_hi = 1'b1;
        win_hi = ID_W'(j);
        rep_hi = pend_rep_q[j];
      end
    end
    win     = any_hi ? win_hi : win_lo;
    win_rep = any_hi ? rep_hi : rep_lo;
    load    = (!valid_q || evt_ready) && any_lo;
    for (int j = 0; j < N_BTN; j++) consume[j] = load && win == ID_W'(j);
  end
  // pending store: a consumed slot can take a new event the same cycle; otherwise a second event is dropped
  always_comb begin
    pending_d  = pending_q;
    pend_rep_d = pend_rep_q;
    overflow_d = ovf_clr ? '0 : overflow_q;
    btn_d      = btn_in;
    post_rst_d = rst;
    for (int j = 0; j < N_BTN; j++) begin
      if (consume[j]) pending_d[j] = 1'b0;
      if (emit[j] && (!pending_q[j] || consume[j])) begin
        pending_d[j]  = 1'b1;
        pend_rep_d[j] = emit_rep[j];
      end else if (emit[j]) overflow_d[j] = 1'b1;
    end
  end
  // output slot: refills whenever empty or accepted, and the pointer moves past the winner
  always_comb begin
    valid_d = (!valid_q || evt_ready) ? any_lo : valid_q;
    id_d    = load ? win : id_q;
    rep_d   = load ? win_rep : rep_q;
    rr_d    = load ? (win == ID_W'(N_BTN - 1) ? '0 : win + 1'b1) : rr_q;
  end
  // shared state registers
  always_ff @(posedge clk) begin
    post_rst_q <= post_rst_d;
    if (rst) begin
      btn_q      <= '0;
      pending_q  <= '0;
      pend_rep_q <= '0;
      overflow_q <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      rep_q      <= 1'b0;
      rr_q       <= '0;
    end else begin
      btn_q      <= btn_d;
      pending_q  <= pending_d;
      pend_rep_q <= pend_rep_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      rep_q      <= rep_d;
      rr_q       <= rr_d;
    end
  end
  assign evt_valid  = valid_q;
  assign evt_id     = id_q;
  assign evt_repeat = rep_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_button_event_scheduler.sv
// tb_button_event_scheduler: directed checks of press/repeat timing, arbitration, backpressure and reset
module tb_button_event_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_in = '0;
  logic       evt_valid, evt_ready = 1'b1, evt_repeat, ovf_clr = 1'b0;
  logic [1:0] evt_id;
  logic [3:0] overflow, obs;
  int         vectors = 0, miscompares = 0;
  button_event_scheduler #(.N_BTN(4), .HOLD_DELAY(8), .REPEAT_PERIOD(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_repeat(evt_repeat), .overflow(overflow), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  assign obs = evt_valid ? {1'b1, evt_id, evt_repeat} : 4'b0;
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    btn_in = '0;
    ovf_clr = 1'b0;
    evt_ready = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask
  task automatic test_reset();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== 4'b0 || evt_id !== 2'b0 || evt_repeat !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_evt got v=%b id=%0d rep=%b want 0", evt_valid, evt_id, evt_repeat);
    end
    vectors++;
    if (overflow !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ovf got %b want 0000", overflow);
    end
  endtask
  task automatic test_single_press();
    logic [3:0] e;
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      next_cycle();
      btn_in = k <= 2 ? 4'b0100 : 4'b0000;
      @(negedge clk);
      e = k == 2 ? 4'b1100 : 4'b0000;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL single_press k=%0d got %b want %b", k, obs, e);
      end
    end
  endtask
  task automatic test_auto_repeat();
    logic [3:0] e;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      next_cycle();
      btn_in = k <= 27 ? 4'b0010 : 4'b0000;
      @(negedge clk);
      e = k == 2 ? 4'b1010 : (k inside {10, 14, 18, 22, 26}) ? 4'b1011 : 4'b0000;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL auto_repeat k=%0d got %b want %b", k, obs, e);
      end
    end
  endtask
  task automatic test_round_robin();
    logic [3:0] e;
    do_reset();
    for (int k = 0; k <= 24; k++) begin
      next_cycle();
      btn_in = k == 0 ? 4'b1111 : k == 8 ? 4'b1010 : k == 14 ? 4'b0010 : k == 18 ? 4'b0101 : 4'b0000;
      @(negedge clk);
      case (k)
        2: e = 4'b1000;
        3: e = 4'b1010;
        4: e = 4'b1100;
        5: e = 4'b1110;
        10: e = 4'b1010;
        11: e = 4'b1110;
        16: e = 4'b1010;
        20: e = 4'b1100;
        21: e = 4'b1000;
        default: e = 4'b0000;
      endcase
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL round_robin k=%0d got %b want %b", k, obs, e);
      end
    end
  endtask
  task automatic test_backpressure();
    logic [3:0] e, eo;
    do_reset();
    evt_ready = 1'b0;
    for (int k = 0; k <= 46; k++) begin
      next_cycle();
      btn_in = k <= 39 ? 4'b0001 : 4'b0000;
      ovf_clr = k == 36 || k == 40;
      evt_ready = k >= 42;
      @(negedge clk);
      e = k < 2 ? 4'b0000 : k <= 42 ? 4'b1000 : k == 43 ? 4'b1001 : 4'b0000;
      eo = (k >= 13 && k <= 40) ? 4'b0001 : 4'b0000;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL backpressure_evt k=%0d got %b want %b", k, obs, e);
      end
      vectors++;
      if (overflow !== eo) begin
        miscompares++;
        $display("FAIL backpressure_ovf k=%0d got %b want %b", k, overflow, eo);
      end
    end
    ovf_clr = 1'b0;
  endtask
  task automatic test_same_cycle_consume();
    logic [3:0] e;
    do_reset();
    evt_ready = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      next_cycle();
      btn_in = k <= 13 ? 4'b0001 : 4'b0000;
      evt_ready = k >= 12;
      @(negedge clk);
      e = k < 2 ? 4'b0000 : k <= 12 ? 4'b1000 : k <= 14 ? 4'b1001 : 4'b0000;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL same_cycle_evt k=%0d got %b want %b", k, obs, e);
      end
      vectors++;
      if (overflow !== 4'b0000) begin
        miscompares++;
        $display("FAIL same_cycle_ovf k=%0d got %b want 0000", k, overflow);
      end
    end
  endtask
  task automatic test_reset_midstream();
    logic [3:0] e;
    do_reset();
    evt_ready = 1'b0;
    for (int k = 0; k <= 36; k++) begin
      next_cycle();
      btn_in = (k <= 30 || k >= 32) ? 4'b1000 : 4'b0000;
      rst = k == 10;
      evt_ready = k >= 11;
      @(negedge clk);
      e = (k >= 2 && k <= 10) || k == 34 ? 4'b1110 : 4'b0000;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_midstream k=%0d got %b want %b", k, obs, e);
      end
      if (k == 11) begin
        vectors++;
        if (overflow !== 4'b0000 || evt_id !== 2'b00 || evt_repeat !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_midstream_clear got ovf=%b id=%0d rep=%b want 0", overflow, evt_id, evt_repeat);
        end
      end
    end
    rst = 1'b0;
  endtask
  task automatic test_release_at_terminal();
    logic [3:0] e;
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      next_cycle();
      btn_in = (k <= 7 || k == 9) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      e = (k == 2 || k == 11) ? 4'b1000 : 4'b0000;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL release_terminal k=%0d got %b want %b", k, obs, e);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_round_robin();
    test_backpressure();
    test_same_cycle_consume();
    test_reset_midstream();
    test_release_at_terminal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
